alu_mc: RTL and testbench

- Parametrised, registered successor to the 1-bit ALU slice: a full WIDTH-bit ALU for the MIPS-subset execute stage.
- Keeps the slice's Ctrl encodings and flag semantics (AND/OR/ADD/XOR/SUB/SLT/SLTU, carry, overflow, set).
- Adds barrel shifts and an iterative shift-add multiplier writing HI/LO.
- Valid/ready handshake on both sides, so the pipeline stalls on multi-cycle ops.

---
 rtl/alu_mc.sv | 201 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: registered WIDTH-bit execute-stage ALU with valid/ready handshakes.
// Single-cycle ops (logic, add/sub, compares, barrel shifts) return their
// result one cycle after acceptance. MULT/MULTU run an iterative shift-add
// multiplier and update the HI/LO product registers on completion.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carryout,
    output logic             Overflow,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SRA   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd10;
    localparam logic [3:0] OP_SLT   = 4'd11;
    localparam logic [3:0] OP_SLTU  = 4'd12;
    localparam logic [3:0] OP_MULT  = 4'd13;
    localparam logic [3:0] OP_MULTU = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                 accept;
    logic                 is_mul;
    logic                 signed_op;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic [SHW-1:0]       shamt;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_o;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 neg_q;
    logic [SHW-1:0]       count_q;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   final_prod;

    assign is_mul    = (Ctrl == OP_MULT) || (Ctrl == OP_MULTU);
    assign signed_op = (Ctrl == OP_MULT);
    assign shamt     = B[SHW-1:0];

    // Both sums carry one extra bit so the MSB carry-out is directly visible.
    assign add_full = {1'b0, A} + {1'b0, B};
    assign sub_full = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (A[MSB] == B[MSB]) && (add_full[MSB] != A[MSB]);
    assign sub_ovf  = (A[MSB] != B[MSB]) && (sub_full[MSB] != A[MSB]);

    // Signed multiply works on magnitudes; the sign is restored at DONE.
    assign a_mag = (signed_op && A[MSB]) ? -A : A;
    assign b_mag = (signed_op && B[MSB]) ? -B : B;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (LSB of the product register) is set.
    assign step_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign final_prod = neg_q ? -prod_q : prod_q;

    assign Zero = (Result == '0);

    // Single-cycle ALU function and flags for the offered operation.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can infer a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (Ctrl)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_ADD: begin
                alu_res = add_full[MSB:0];
                alu_c   = add_full[WIDTH];
                alu_o   = add_ovf;
            end
            OP_SUB: begin
                alu_res = sub_full[MSB:0];
                alu_c   = sub_full[WIDTH];
                alu_o   = sub_ovf;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, sub_full[MSB] ^ sub_ovf};
                alu_c   = sub_full[WIDTH];
                alu_o   = sub_ovf;
            end
            OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
                alu_c   = sub_full[WIDTH];
            end
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, input handshake and acceptance.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && is_mul) state_d = MUL;
            end
            MUL: begin
                if (count_q == SHW'(WIDTH - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiplier datapath: operand latch on accept, one step per MUL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            count_q <= '0;
        end else if (accept && is_mul) begin
            mcand_q <= a_mag;
            prod_q  <= {{WIDTH{1'b0}}, b_mag};
            neg_q   <= signed_op && (A[MSB] ^ B[MSB]);
            count_q <= '0;
        end else if (state_q == MUL) begin
            prod_q  <= {step_sum, prod_q[WIDTH-1:1]};
            count_q <= count_q + SHW'(1);
        end
    end

    // Output registers: result/flags, HI/LO and output-side handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Result    <= '0;
            Carryout  <= 1'b0;
            Overflow  <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            Result    <= alu_res;
            Carryout  <= alu_c;
            Overflow  <= alu_o;
        end else if (state_q == DONE) begin
            out_valid <= 1'b1;
            Result    <= final_prod[WIDTH-1:0];
            Carryout  <= 1'b0;
            Overflow  <= 1'b0;
            Hi        <= final_prod[2*WIDTH-1:WIDTH];
            Lo        <= final_prod[WIDTH-1:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized bench for alu_mc (WIDTH = 32) checked
// against a transaction-level reference model kept in the bench.
module tb_alu_mc;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  A         = '0;
    logic [W-1:0]  B         = '0;
    logic [3:0]    Ctrl      = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  Result;
    logic          Carryout;
    logic          Overflow;
    logic          Zero;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit ready_mode = 1'b0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ctrl      (Ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Carryout  (Carryout),
        .Overflow  (Overflow),
        .Zero      (Zero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } alu_t;

    function automatic alu_t model_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_t   r;
        longint sa, sb, sd;
        int     sh;
        r  = '0;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b[4:0]);
        case (op)
            4'd0: r.res = a & b;
            4'd1: r.res = a | b;
            4'd3: r.res = a ^ b;
            4'd2: begin
                r.res = a + b;
                r.c   = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                sd    = sa + sb;
                r.o   = (sd > SMAX) || (sd < SMIN);
            end
            4'd10: begin
                r.res = a - b;
                r.c   = (a >= b);
                sd    = sa - sb;
                r.o   = (sd > SMAX) || (sd < SMIN);
            end
            4'd11: begin
                r.res = (sa < sb) ? 32'd1 : 32'd0;
                r.c   = (a >= b);
                sd    = sa - sb;
                r.o   = (sd > SMAX) || (sd < SMIN);
            end
            4'd12: begin
                r.res = (a < b) ? 32'd1 : 32'd0;
                r.c   = (a >= b);
            end
            4'd4: r.res = a << sh;
            4'd5: r.res = a >> sh;
            4'd6: r.res = 32'(sa >>> sh);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] model_mul(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        if (op == 4'd13) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            return p;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    logic [W-1:0] exp_res   = '0;
    logic         exp_c     = 1'b0;
    logic         exp_o     = 1'b0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_hi    = '0;
    logic [W-1:0] exp_lo    = '0;
    logic [63:0]  mul_prod  = '0;
    int           mul_left  = 0;

    function automatic logic model_in_ready();
        return (mul_left == 0) && (!exp_valid || out_ready);
    endfunction

    // Model update: a multiply completes WIDTH+1 edges after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid <= 1'b0;
            exp_res   <= '0;
            exp_c     <= 1'b0;
            exp_o     <= 1'b0;
            exp_hi    <= '0;
            exp_lo    <= '0;
            mul_left  <= 0;
        end else if (mul_left > 0) begin
            mul_left <= mul_left - 1;
            if (mul_left == 1) begin
                exp_valid <= 1'b1;
                exp_res   <= mul_prod[31:0];
                exp_c     <= 1'b0;
                exp_o     <= 1'b0;
                exp_hi    <= mul_prod[63:32];
                exp_lo    <= mul_prod[31:0];
            end
        end else if (in_valid && model_in_ready()) begin
            if (Ctrl == 4'd13 || Ctrl == 4'd14) begin
                mul_prod  <= model_mul(Ctrl, A, B);
                mul_left  <= W + 1;
                exp_valid <= 1'b0;
            end else begin
                {exp_res, exp_c, exp_o} <= model_alu(Ctrl, A, B);
                exp_valid <= 1'b1;
            end
        end else if (out_ready) begin
            exp_valid <= 1'b0;
        end
    end

    // Compare process: every falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(model_in_ready()));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("hi", 64'(Hi), 64'(exp_hi));
            check("lo", 64'(Lo), 64'(exp_lo));
            if (exp_valid) begin
                check("result", 64'(Result), 64'(exp_res));
                check("carryout", 64'(Carryout), 64'(exp_c));
                check("overflow", 64'(Overflow), 64'(exp_o));
                check("zero", 64'(Zero), 64'(exp_res == '0));
            end
        end
    end

    // Randomized back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit done;
        int n;
        in_valid = 1'b1;
        Ctrl     = op;
        A        = a;
        B        = b;
        done     = 1'b0;
        n        = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("accept_timeout", 64'(done), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic op_check(input string name, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] r, input logic c, input logic o);
        drive_op(op, a, b);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_result"}, 64'(Result), 64'(r));
        check({name, "_carry"}, 64'(Carryout), 64'(c));
        check({name, "_ovf"}, 64'(Overflow), 64'(o));
        check({name, "_zero"}, 64'(Zero), 64'(r == '0));
        @(posedge clk);
        #1;
    endtask

    task automatic mul_check(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
        int n;
        bit busy_low;
        drive_op(op, a, b);
        n        = 0;
        busy_low = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) busy_low = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd33);
        check({name, "_in_ready_low"}, 64'(busy_low), 64'd1);
        check({name, "_hi"}, 64'(Hi), 64'(hi));
        check({name, "_lo"}, 64'(Lo), 64'(lo));
        check({name, "_result"}, 64'(Result), 64'(lo));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] sums [1:4];
        logic [W-1:0] oa, ob;
        bit seen;

        // Pin the reference model with hand-computed values.
        check("pin_add", 64'(model_alu(4'd2, 32'h7FFF_FFFF, 32'd1)), 64'({32'h8000_0000, 1'b0, 1'b1}));
        check("pin_sub", 64'(model_alu(4'd10, 32'd5, 32'd5)), 64'({32'h0, 1'b1, 1'b0}));
        check("pin_sltu", 64'(model_alu(4'd12, 32'd1, 32'd2)), 64'({32'h1, 1'b0, 1'b0}));
        check("pin_slt", 64'(model_alu(4'd11, 32'h8000_0000, 32'd1)), 64'({32'h1, 1'b1, 1'b1}));
        check("pin_sra", 64'(model_alu(4'd6, 32'hF000_0000, 32'h24)), 64'({32'hFF00_0000, 1'b0, 1'b0}));
        check("pin_mult", model_mul(4'd13, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        check("pin_multu", model_mul(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_zero", 64'(Zero), 64'd1);
        check("rst_hi_lo", {Hi, Lo}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arithmetic, compares and shifts.
        op_check("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
        op_check("sub_eq", 4'd10, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        op_check("sltu", 4'd12, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0);
        op_check("slt_min", 4'd11, 32'h8000_0000, 32'd1, 32'd1, 1'b1, 1'b1);
        op_check("sra", 4'd6, 32'hF000_0000, 32'h24, 32'hFF00_0000, 1'b0, 1'b0);
        op_check("sll", 4'd4, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        op_check("undef", 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);

        // Multiplies.
        mul_check("mult", 4'd13, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        mul_check("multu", 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Back-pressure, then back-to-back release.
        for (int k = 1; k <= 4; k++) sums[k] = 32'(k * 1000) + 32'h10;
        out_ready = 1'b0;
        drive_op(4'd2, 32'd1000, 32'h10);
        in_valid = 1'b1;
        Ctrl     = 4'd2;
        A        = 32'd2000;
        B        = 32'h10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", 64'(Result), 64'(sums[1]));
            check("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            in_valid = 1'b1;
            Ctrl     = 4'd2;
            A        = 32'(k * 1000);
            B        = 32'h10;
            @(negedge clk);
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_result", 64'(Result), 64'(sums[k-1]));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", 64'(out_valid), 64'd1);
        check("b2b_last_result", 64'(Result), 64'(sums[4]));
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        drive_op(4'd13, 32'h0001_2345, 32'hFFFF_0F0F);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_hi_lo", {Hi, Lo}, 64'd0);
        check("abort_zero", 64'(Zero), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_silent", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        op_check("post_abort_add", 4'd2, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure and idle gaps.
        ready_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    A    = $urandom;
                    B    = $urandom;
                    Ctrl = 4'($urandom_range(0, 15));
                    @(posedge clk);
                    #1;
                end
            end
            oa = pick_operand();
            ob = pick_operand();
            drive_op(4'($urandom_range(0, 15)), oa, ob);
        end
        ready_mode = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
